// File: rtl/squash_spi_ctrl.sv
// SPI-fed paddle/game control for the squash game: receives 16-bit command frames,
// stages them in shadow registers and commits them only on the frame boundary.
`timescale 1ns/1ps
module squash_spi_ctrl #(
    parameter int PADDLE_MIN   = 32,
    parameter int PADDLE_MAX   = 384,
    parameter int PADDLE_RESET = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_ss_n,
    input  logic       frame_tick,
    output logic [8:0] paddle_pos,
    output logic       paddle_override,
    output logic       pause_req,
    output logic       new_game,
    output logic [1:0] ball_speed,
    output logic [3:0] err_count
);

    localparam logic [8:0] P_MIN   = 9'(PADDLE_MIN);
    localparam logic [8:0] P_MAX   = 9'(PADDLE_MAX);
    localparam logic [8:0] P_RESET = 9'(PADDLE_RESET);

    localparam logic [3:0] CMD_NOP    = 4'h0;
    localparam logic [3:0] CMD_PADDLE = 4'h1;
    localparam logic [3:0] CMD_KEYS   = 4'h2;
    localparam logic [3:0] CMD_PAUSE  = 4'h3;
    localparam logic [3:0] CMD_NEW    = 4'h4;
    localparam logic [3:0] CMD_SPEED  = 4'h5;

    function automatic logic [8:0] clamp_paddle(input logic [8:0] v);
        if (v < P_MIN) return P_MIN;
        if (v > P_MAX) return P_MAX;
        return v;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [1:0] map_speed(input logic [1:0] v);
        return (v == 2'd0) ? 2'd1 : v;
    endfunction

    // SPI front end
    logic [2:0]  sclk_sync_q, sclk_sync_d;
    logic [1:0]  ss_sync_q, ss_sync_d;
    logic [1:0]  mosi_sync_q, mosi_sync_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [14:0] shift_q, shift_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [8:0]  data_q, data_d;
    logic        frame_vld_q, frame_vld_d;
    logic        sclk_rise, ss_active, mosi_s;

    // Shadow registers with their pending bits
    logic [8:0]  paddle_sh_q, paddle_sh_d;
    logic        paddle_pend_q, paddle_pend_d;
    logic        ovr_sh_q, ovr_sh_d;
    logic        ovr_pend_q, ovr_pend_d;
    logic        pause_sh_q, pause_sh_d;
    logic        pause_pend_q, pause_pend_d;
    logic [1:0]  speed_sh_q, speed_sh_d;
    logic        speed_pend_q, speed_pend_d;
    logic        ng_pend_q, ng_pend_d;

    // Committed outputs
    logic [8:0]  paddle_q, paddle_d;
    logic        ovr_q, ovr_d;
    logic        pause_q, pause_d;
    logic        new_game_q, new_game_d;
    logic [1:0]  speed_q, speed_d;
    logic [3:0]  err_q, err_d;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], spi_sclk};
        ss_sync_d   = {ss_sync_q[0], spi_ss_n};
        mosi_sync_d = {mosi_sync_q[0], spi_mosi};

        sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
        ss_active = ~ss_sync_q[1];
        mosi_s    = mosi_sync_q[1];

        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        frame_vld_d = 1'b0;

        // The 4-bit counter wraps after bit 16, so frames may run back to back.
        if (!ss_active) begin
            bit_cnt_d = 4'd0;
        end else if (sclk_rise) begin
            shift_d   = {shift_q[13:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
                cmd_d       = shift_q[14:11];
                data_d      = {shift_q[7:0], mosi_s};
                frame_vld_d = 1'b1;
            end
        end
    end

    always_comb begin
        paddle_sh_d   = paddle_sh_q;
        paddle_pend_d = paddle_pend_q;
        ovr_sh_d      = ovr_sh_q;
        ovr_pend_d    = ovr_pend_q;
        pause_sh_d    = pause_sh_q;
        pause_pend_d  = pause_pend_q;
        speed_sh_d    = speed_sh_q;
        speed_pend_d  = speed_pend_q;
        ng_pend_d     = ng_pend_q;
        paddle_d      = paddle_q;
        ovr_d         = ovr_q;
        pause_d       = pause_q;
        speed_d       = speed_q;
        err_d         = err_q;
        new_game_d    = 1'b0;

        // Commit first, then stage: a frame decoded on the tick waits for the next one.
        if (frame_tick) begin
            if (paddle_pend_q) paddle_d = paddle_sh_q;
            if (ovr_pend_q)    ovr_d    = ovr_sh_q;
            if (pause_pend_q)  pause_d  = pause_sh_q;
            if (speed_pend_q)  speed_d  = speed_sh_q;
            new_game_d    = ng_pend_q;
            paddle_pend_d = 1'b0;
            ovr_pend_d    = 1'b0;
            pause_pend_d  = 1'b0;
            speed_pend_d  = 1'b0;
            ng_pend_d     = 1'b0;
        end

        if (frame_vld_q) begin
            case (cmd_q)
                CMD_NOP: ;
                CMD_PADDLE: begin
                    paddle_sh_d   = clamp_paddle(data_q);
                    paddle_pend_d = 1'b1;
                    ovr_sh_d      = 1'b1;
                    ovr_pend_d    = 1'b1;
                end
                CMD_KEYS: begin
                    ovr_sh_d   = 1'b0;
                    ovr_pend_d = 1'b1;
                end
                CMD_PAUSE: begin
                    pause_sh_d   = data_q[0];
                    pause_pend_d = 1'b1;
                end
                CMD_NEW:   ng_pend_d = 1'b1;
                CMD_SPEED: begin
                    speed_sh_d   = map_speed(data_q[1:0]);
                    speed_pend_d = 1'b1;
                end
                default:   err_d = sat_inc(err_q);
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q   <= 3'b000;
            ss_sync_q     <= 2'b11;
            mosi_sync_q   <= 2'b00;
            bit_cnt_q     <= 4'd0;
            frame_vld_q   <= 1'b0;
            paddle_sh_q   <= 9'd0;
            paddle_pend_q <= 1'b0;
            ovr_sh_q      <= 1'b0;
            ovr_pend_q    <= 1'b0;
            pause_sh_q    <= 1'b0;
            pause_pend_q  <= 1'b0;
            speed_sh_q    <= 2'd0;
            speed_pend_q  <= 1'b0;
            ng_pend_q     <= 1'b0;
            paddle_q      <= P_RESET;
            ovr_q         <= 1'b0;
            pause_q       <= 1'b0;
            new_game_q    <= 1'b0;
            speed_q       <= 2'd3;
            err_q         <= 4'd0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            ss_sync_q     <= ss_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_vld_q   <= frame_vld_d;
            paddle_sh_q   <= paddle_sh_d;
            paddle_pend_q <= paddle_pend_d;
            ovr_sh_q      <= ovr_sh_d;
            ovr_pend_q    <= ovr_pend_d;
            pause_sh_q    <= pause_sh_d;
            pause_pend_q  <= pause_pend_d;
            speed_sh_q    <= speed_sh_d;
            speed_pend_q  <= speed_pend_d;
            ng_pend_q     <= ng_pend_d;
            paddle_q      <= paddle_d;
            ovr_q         <= ovr_d;
            pause_q       <= pause_d;
            new_game_q    <= new_game_d;
            speed_q       <= speed_d;
            err_q         <= err_d;
        end
    end

    // Pure datapath: only meaningful when frame_vld_q is set, so no reset needed.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        cmd_q   <= cmd_d;
        data_q  <= data_d;
    end

    assign paddle_pos      = paddle_q;
    assign paddle_override = ovr_q;
    assign pause_req       = pause_q;
    assign new_game        = new_game_q;
    assign ball_speed      = speed_q;
    assign err_count       = err_q;

endmodule

// File: tb/tb_squash_spi_ctrl.sv
// Randomised bench for squash_spi_ctrl: SPI frames are checked against a
// frame-queue reference model that applies staged commands at each frame_tick.
`timescale 1ns/1ps
module tb_squash_spi_ctrl;

    localparam int PMIN = 32;
    localparam int PMAX = 384;
    localparam int PRST = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_ss_n = 1'b1;
    logic       frame_tick = 1'b0;
    logic [8:0] paddle_pos;
    logic       paddle_override;
    logic       pause_req;
    logic       new_game;
    logic [1:0] ball_speed;
    logic [3:0] err_count;

    squash_spi_ctrl #(
        .PADDLE_MIN(PMIN), .PADDLE_MAX(PMAX), .PADDLE_RESET(PRST)
    ) dut (
        .clk(clk), .reset(reset),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
        .frame_tick(frame_tick),
        .paddle_pos(paddle_pos), .paddle_override(paddle_override),
        .pause_req(pause_req), .new_game(new_game),
        .ball_speed(ball_speed), .err_count(err_count)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: committed values plus the list of frames seen since the last tick.
    int          m_paddle, m_ovr, m_pause, m_speed, m_err;
    int          exp_ng;
    logic [15:0] m_q[$];

    task automatic model_reset();
        m_paddle = PRST; m_ovr = 0; m_pause = 0; m_speed = 3; m_err = 0; exp_ng = 0;
        m_q.delete();
    endtask

    task automatic model_push(input logic [15:0] f);
        m_q.push_back(f);
        if (int'(f[15:12]) > 5 && m_err < 15) m_err = m_err + 1;
    endtask

    task automatic model_tick();
        int c, d;
        exp_ng = 0;
        foreach (m_q[i]) begin
            c = int'(m_q[i][15:12]);
            d = int'(m_q[i][8:0]);
            case (c)
                1: begin
                    m_paddle = (d < PMIN) ? PMIN : ((d > PMAX) ? PMAX : d);
                    m_ovr = 1;
                end
                2: m_ovr = 0;
                3: m_pause = d % 2;
                4: exp_ng = 1;
                5: m_speed = ((d % 4) == 0) ? 1 : (d % 4);
                default: ;
            endcase
        end
        m_q.delete();
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int ng);
        check({tag, "_paddle"}, int'(paddle_pos), m_paddle);
        check({tag, "_ovr"},    int'(paddle_override), m_ovr);
        check({tag, "_pause"},  int'(pause_req), m_pause);
        check({tag, "_speed"},  int'(ball_speed), m_speed);
        check({tag, "_err"},    int'(err_count), m_err);
        check({tag, "_newgame"}, int'(new_game), ng);
    endtask

    task automatic do_tick(input string tag);
        @(posedge clk); #1 frame_tick = 1'b1;
        model_tick();
        @(posedge clk); #1 frame_tick = 1'b0;
        check_all(tag, exp_ng);
        @(posedge clk); #1;
        check({tag, "_newgame_end"}, int'(new_game), 0);
    endtask

    // Sends nbits of w MSB first. coincide lines the last decode up with a frame_tick.
    task automatic spi_send(input logic [31:0] w, input int nbits, input bit coincide, input bit keep_ss);
        int off;
        if (spi_ss_n) begin
            @(posedge clk); #1 spi_ss_n = 1'b0;
            repeat (3) @(posedge clk);
        end
        for (int i = nbits - 1; i >= 0; i--) begin
            off = coincide ? 1 : int'($urandom_range(1, 30));
            @(posedge clk); #(off) spi_mosi = w[i];
            repeat (int'($urandom_range(2, 4))) @(posedge clk);
            #(off) spi_sclk = 1'b1;
            if (coincide && i == 0) begin
                repeat (3) @(posedge clk);
                #1 frame_tick = 1'b1;
                model_tick();
                @(posedge clk); #1 frame_tick = 1'b0;
                check_all("coincide_tick", exp_ng);
            end else begin
                repeat (int'($urandom_range(3, 5))) @(posedge clk);
            end
            #(off) spi_sclk = 1'b0;
        end
        if (nbits >= 32) model_push(w[31:16]);
        if (nbits >= 16) model_push(w[15:0]);
        if (!keep_ss) begin
            repeat (3) @(posedge clk);
            #1 spi_ss_n = 1'b1;
        end
        repeat (4) @(posedge clk);
    endtask

    function automatic logic [15:0] rand_frame(input int cmd);
        logic [15:0] f;
        f = 16'($urandom);
        f[15:12] = 4'(cmd);
        return f;
    endfunction

    initial begin
        #3_800_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0]  edge_vals [8];
        logic [15:0] f;
        int          k;
        edge_vals = '{9'd0, 9'd31, 9'd32, 9'd33, 9'd383, 9'd384, 9'd385, 9'd511};

        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all("reset", 0);
        check("reset_paddle_abs", int'(paddle_pos), 64);
        check("reset_speed_abs", int'(ball_speed), 3);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Paddle set: visible only after the tick
        spi_send(32'h10C8, 16, 0, 0);
        check_all("r33_pre", 0);
        do_tick("r33");
        check("r33_paddle_abs", int'(paddle_pos), 200);
        check("r33_ovr_abs", int'(paddle_override), 1);

        // Last wins plus clamp to the maximum
        spi_send(32'h1005, 16, 0, 0);
        spi_send(32'h11FF, 16, 0, 0);
        check_all("r34_pre", 0);
        do_tick("r34");
        check("r34_paddle_abs", int'(paddle_pos), 384);

        // Partial frame discarded, then pause
        spi_send(32'hA5, 8, 0, 0);
        spi_send(32'h3001, 16, 0, 0);
        do_tick("r35");
        check("r35_pause_abs", int'(pause_req), 1);
        check("r35_err_abs", int'(err_count), 0);
        check("r35_paddle_abs", int'(paddle_pos), 384);

        // New-game decode coincident with a tick is held for the next tick
        spi_send(32'h4000, 16, 1, 0);
        do_tick("r36");
        check("r36_pulse_abs", exp_ng, 1);

        // Error saturation and speed mapping of zero
        for (int i = 0; i < 17; i++) spi_send({16'h0, rand_frame(15)}, 16, 0, 0);
        check("r37_err_abs", int'(err_count), 15);
        spi_send(32'h5000, 16, 0, 0);
        do_tick("r37");
        check("r37_speed_abs", int'(ball_speed), 1);

        // Back-to-back frames under one ss_n assertion
        spi_send({16'h3000, 16'h5002}, 32, 0, 0);
        do_tick("b2b");
        check("b2b_speed_abs", int'(ball_speed), 2);
        check("b2b_pause_abs", int'(pause_req), 0);

        // Randomised traffic
        for (int it = 0; it < 25; it++) begin
            for (int op = 0; op < int'($urandom_range(1, 3)); op++) begin
                k = int'($urandom_range(0, 10));
                if (k <= 5)       spi_send({16'h0, rand_frame(int'($urandom_range(0, 5)))}, 16, 0, 0);
                else if (k == 6)  spi_send({rand_frame(int'($urandom_range(0, 5))),
                                            rand_frame(int'($urandom_range(0, 5)))}, 32, 0, 0);
                else if (k == 7)  spi_send($urandom, int'($urandom_range(1, 15)), 0, 0);
                else if (k == 8)  spi_send({16'h0, rand_frame(int'($urandom_range(0, 15)))}, 16, 0, 0);
                else if (k == 9) begin
                    f = rand_frame(1);
                    f[8:0] = edge_vals[$urandom_range(0, 7)];
                    spi_send({16'h0, f}, 16, 0, 0);
                end else          spi_send({16'h0, rand_frame(int'($urandom_range(1, 5)))}, 16, 1, 0);
            end
            check_all("rnd_pre", 0);
            do_tick("rnd");
        end

        // Reset mid-frame with a key-control frame pending
        spi_send(32'h10C8, 16, 0, 0);
        do_tick("r38_setup");
        spi_send(32'h2000, 16, 0, 0);
        check_all("r38_pending", 0);
        f = 16'($urandom);
        spi_send({16'h0, f}, 5, 0, 1);
        #7 reset = 1'b1;
        #1;
        model_reset();
        check_all("r38_reset", 0);
        check("r38_paddle_abs", int'(paddle_pos), 64);
        check("r38_ovr_abs", int'(paddle_override), 0);
        @(posedge clk); #1 reset = 1'b0;
        spi_send({16'h0, f}, 11, 0, 0);
        do_tick("r38_tick");
        check("r38_tick_speed_abs", int'(ball_speed), 3);
        spi_send(32'h10C8, 16, 0, 0);
        do_tick("r38_after");
        check("r38_after_paddle_abs", int'(paddle_pos), 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
